// File: rtl/rsa_uart_pkg.sv
// Shared constants and types for the UART <-> RSA-256 bridge.
package rsa_uart_pkg;

  localparam int unsigned ADDR_W      = 5;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned KEY_W       = 256;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned CNT_W       = 5;
  localparam int unsigned RX_BYTES    = 32;
  localparam int unsigned TX_BYTES    = 31;
  localparam int unsigned SEND_W      = TX_BYTES * BYTE_W;

  localparam int unsigned RX_BASE     = 0;
  localparam int unsigned TX_BASE     = 1;
  localparam int unsigned STATUS_BASE = 2;
  localparam int unsigned TX_OK_BIT   = 6;
  localparam int unsigned RX_OK_BIT   = 7;

  typedef enum logic [2:0] {
    S_GET_KEY_N,
    S_GET_KEY_D,
    S_GET_DATA,
    S_WAIT_CALC,
    S_SEND_DATA
  } state_e;

  typedef enum logic {
    P_POLL,
    P_XFER
  } phase_e;

  function automatic logic [ADDR_W-1:0] byte_addr(input int unsigned offset);
    return ADDR_W'(offset * 4);
  endfunction

endpackage

// File: rtl/rsa_avm_byte_port.sv
// Single-byte Avalon-MM engine: polls UART status, then reads RX or writes TX.
module rsa_avm_byte_port
  import rsa_uart_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                req,
  input  logic                dir,
  input  logic [BYTE_W-1:0]   wdata,
  output logic                done_c,
  output logic [BYTE_W-1:0]   rdata_c,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  input  logic [DATA_W-1:0]   avm_readdata,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  input  logic                avm_waitrequest
);

  phase_e              phase_q, phase_d;
  logic                rd_d, wr_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   wdat_d;
  logic                busy, accept, ok_bit;
  logic                unused_rdata;

  assign busy         = avm_read | avm_write;
  assign accept       = busy & ~avm_waitrequest;
  assign ok_bit       = dir ? avm_readdata[TX_OK_BIT] : avm_readdata[RX_OK_BIT];
  assign done_c       = accept & (phase_q == P_XFER);
  assign rdata_c      = avm_readdata[BYTE_W-1:0];
  assign unused_rdata = ^avm_readdata[DATA_W-1:BYTE_W];

  // A completed access always drops the request, which guarantees the idle gap.
  always_comb begin
    phase_d = phase_q;
    rd_d    = avm_read;
    wr_d    = avm_write;
    addr_d  = avm_address;
    wdat_d  = avm_writedata;
    if (accept) begin
      rd_d = 1'b0;
      wr_d = 1'b0;
      if (phase_q == P_POLL) begin
        if (ok_bit) phase_d = P_XFER;
      end else begin
        phase_d = P_POLL;
      end
    end else if (!busy && req) begin
      if (phase_q == P_POLL) begin
        rd_d   = 1'b1;
        addr_d = byte_addr(STATUS_BASE);
      end else if (dir) begin
        wr_d   = 1'b1;
        addr_d = byte_addr(TX_BASE);
        wdat_d = DATA_W'(wdata);
      end else begin
        rd_d   = 1'b1;
        addr_d = byte_addr(RX_BASE);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      phase_q       <= P_POLL;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_address   <= byte_addr(STATUS_BASE);
      avm_writedata <= '0;
    end else begin
      phase_q       <= phase_d;
      avm_read      <= rd_d;
      avm_write     <= wr_d;
      avm_address   <= addr_d;
      avm_writedata <= wdat_d;
    end
  end

endmodule

// File: rtl/rsa_uart_wrapper.sv
// Bridges a byte-serial UART to the RSA-256 core: loads key, feeds ciphertext, returns plaintext.
module rsa_uart_wrapper
  import rsa_uart_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  output logic [ADDR_W-1:0]  avm_address,
  output logic               avm_read,
  input  logic [DATA_W-1:0]  avm_readdata,
  output logic               avm_write,
  output logic [DATA_W-1:0]  avm_writedata,
  input  logic               avm_waitrequest,
  output logic               o_rsa_start,
  output logic [KEY_W-1:0]   o_rsa_a,
  output logic [KEY_W-1:0]   o_rsa_d,
  output logic [KEY_W-1:0]   o_rsa_n,
  input  logic [KEY_W-1:0]   i_rsa_a_pow_d,
  input  logic               i_rsa_finished
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                start_d;
  logic [SEND_W-1:0]   res_q;
  logic                req, dir, done_c;
  logic [BYTE_W-1:0]   rdata_c;
  logic                last_rx, last_tx;
  logic                unused_res_top;

  assign req            = (state_q != S_WAIT_CALC);
  assign dir            = (state_q == S_SEND_DATA);
  assign last_rx        = (cnt_q == CNT_W'(RX_BYTES - 1));
  assign last_tx        = (cnt_q == CNT_W'(TX_BYTES - 1));
  assign unused_res_top = ^i_rsa_a_pow_d[KEY_W-1:SEND_W];

  rsa_avm_byte_port u_port (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .req             (req),
    .dir             (dir),
    .wdata           (res_q[SEND_W-1 -: BYTE_W]),
    .done_c          (done_c),
    .rdata_c         (rdata_c),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_readdata    (avm_readdata),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_waitrequest (avm_waitrequest)
  );

  // Next-state, byte counter and start pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    case (state_q)
      S_GET_KEY_N: if (done_c) begin
        cnt_d = cnt_q + CNT_W'(1);
        if (last_rx) state_d = S_GET_KEY_D;
      end
      S_GET_KEY_D: if (done_c) begin
        cnt_d = cnt_q + CNT_W'(1);
        if (last_rx) state_d = S_GET_DATA;
      end
      S_GET_DATA: if (done_c) begin
        cnt_d = cnt_q + CNT_W'(1);
        if (last_rx) begin
          state_d = S_WAIT_CALC;
          start_d = 1'b1;
        end
      end
      S_WAIT_CALC: if (i_rsa_finished) state_d = S_SEND_DATA;
      S_SEND_DATA: if (done_c) begin
        if (last_tx) begin
          cnt_d   = '0;
          state_d = S_GET_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_GET_KEY_N;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= S_GET_KEY_N;
      cnt_q       <= '0;
      o_rsa_start <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      o_rsa_start <= start_d;
    end
  end

  // Byte-serial shift registers; the top plaintext byte is never transmitted.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_rsa_n <= '0;
      o_rsa_d <= '0;
      o_rsa_a <= '0;
      res_q   <= '0;
    end else begin
      if (done_c) begin
        case (state_q)
          S_GET_KEY_N: o_rsa_n <= {o_rsa_n[KEY_W-BYTE_W-1:0], rdata_c};
          S_GET_KEY_D: o_rsa_d <= {o_rsa_d[KEY_W-BYTE_W-1:0], rdata_c};
          S_GET_DATA:  o_rsa_a <= {o_rsa_a[KEY_W-BYTE_W-1:0], rdata_c};
          S_SEND_DATA: res_q   <= {res_q[SEND_W-BYTE_W-1:0], BYTE_W'(0)};
          default: ;
        endcase
      end
      if ((state_q == S_WAIT_CALC) && i_rsa_finished) res_q <= i_rsa_a_pow_d[SEND_W-1:0];
    end
  end

endmodule

// File: tb/tb_rsa_uart_wrapper.sv
// Bench for rsa_uart_wrapper: UART slave model, core model and byte-level scoreboard.
`timescale 1ns/1ps
module tb_rsa_uart_wrapper;

  localparam logic [4:0] A_RX = 5'd0;
  localparam logic [4:0] A_TX = 5'd4;
  localparam logic [4:0] A_ST = 5'd8;
  localparam int unsigned TXOK = 6;
  localparam int unsigned RXOK = 7;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b0;
  logic [4:0]   avm_address;
  logic         avm_read, avm_write;
  logic [31:0]  avm_readdata = '0;
  logic [31:0]  avm_writedata;
  logic         avm_waitrequest = 1'b0;
  logic         o_rsa_start;
  logic [255:0] o_rsa_a, o_rsa_d, o_rsa_n;
  logic [255:0] i_rsa_a_pow_d = '0;
  logic         i_rsa_finished = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [7:0]   rx_q[$], tx_q[$], cipher_q[$], exp_tx[$];
  logic [255:0] exp_n = '0, exp_d = '0;
  int unsigned  ncyc = 0, start_cnt = 0, start_ncyc = 0, last_rx_ncyc = 0;
  int unsigned  status_reads = 0, polls = 0, rx_hold = 5, stall = 0;
  bit           fixed_stall = 1'b1, in_req = 1'b0, just_done = 1'b0;
  bit           rx_grant = 1'b0, tx_grant = 1'b0;
  logic         h_rd, h_wr;
  logic [4:0]   h_addr;
  logic [31:0]  h_wd;

  always #5 i_clk = ~i_clk;

  rsa_uart_wrapper dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_readdata    (avm_readdata),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_waitrequest (avm_waitrequest),
    .o_rsa_start     (o_rsa_start),
    .o_rsa_a         (o_rsa_a),
    .o_rsa_d         (o_rsa_d),
    .o_rsa_n         (o_rsa_n),
    .i_rsa_a_pow_d   (i_rsa_a_pow_d),
    .i_rsa_finished  (i_rsa_finished)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // UART slave: stalls with waitrequest, gates RX/TX readiness, captures TX bytes.
  always @(negedge i_clk) begin
    logic [31:0] rd;
    bit rx_ok, tx_ok;
    ncyc++;
    if (o_rsa_start) begin
      start_cnt++;
      start_ncyc = ncyc;
    end
    if (!i_rst) begin
      in_req = 0; just_done = 0; rx_grant = 0; tx_grant = 0; polls = 0;
      avm_waitrequest = 1'b0;
    end else begin
      if (just_done) chk("idle_gap", 256'(avm_read | avm_write), 256'(0));
      just_done = 0;
      if (avm_read | avm_write) begin
        if (!in_req) begin
          in_req = 1;
          stall  = fixed_stall ? 3 : $urandom_range(0, 3);
          h_rd = avm_read; h_wr = avm_write; h_addr = avm_address; h_wd = avm_writedata;
        end else begin
          chk("hold_stable", 256'({avm_read, avm_write, avm_address, avm_writedata}),
              256'({h_rd, h_wr, h_addr, h_wd}));
        end
        if (stall > 0) begin
          avm_waitrequest = 1'b1;
          stall--;
          avm_readdata = $urandom;
        end else begin
          avm_waitrequest = 1'b0;
          in_req = 0;
          just_done = 1;
          rd = $urandom;
          if (avm_write) begin
            chk("wr_addr", 256'(avm_address), 256'(A_TX));
            chk("tx_ok_before_wr", 256'(tx_grant), 256'(1));
            chk("wd_upper_zero", 256'(avm_writedata[31:8]), 256'(0));
            tx_q.push_back(avm_writedata[7:0]);
            tx_grant = 0;
          end else if (avm_address == A_ST) begin
            status_reads++;
            rx_ok = (rx_q.size() > 0) && (polls >= rx_hold);
            tx_ok = ($urandom_range(0, 2) != 0);
            rd[RXOK] = rx_ok;
            rd[TXOK] = tx_ok;
            rx_grant = rx_ok;
            tx_grant = tx_ok;
            polls++;
          end else begin
            chk("rd_addr", 256'(avm_address), 256'(A_RX));
            chk("rx_ok_before_rd", 256'(rx_grant), 256'(1));
            if (rx_q.size() > 0) rd[7:0] = rx_q.pop_front();
            rx_grant = 0;
            polls = 0;
            last_rx_ncyc = ncyc;
          end
          avm_readdata = rd;
        end
      end else begin
        chk("req_not_dropped", 256'(in_req), 256'(0));
        in_req = 0;
        avm_waitrequest = 1'b0;
      end
    end
  end

  task automatic tick();
    @(negedge i_clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_read"},  256'(avm_read), 256'(0));
    chk({tag, "_write"}, 256'(avm_write), 256'(0));
    chk({tag, "_addr"},  256'(avm_address), 256'(A_ST));
    chk({tag, "_wdata"}, 256'(avm_writedata), 256'(0));
    chk({tag, "_start"}, 256'(o_rsa_start), 256'(0));
    chk({tag, "_n"}, o_rsa_n, 256'(0));
    chk({tag, "_d"}, o_rsa_d, 256'(0));
    chk({tag, "_a"}, o_rsa_a, 256'(0));
  endtask

  task automatic load_key(input bit fixed);
    logic [7:0] b;
    exp_n = '0;
    exp_d = '0;
    for (int i = 0; i < 32; i++) begin
      b = fixed ? 8'(i + 1) : 8'($urandom);
      rx_q.push_back(b);
      exp_n = {exp_n[247:0], b};
    end
    for (int i = 0; i < 32; i++) begin
      b = fixed ? 8'hFF : 8'($urandom);
      rx_q.push_back(b);
      exp_d = {exp_d[247:0], b};
    end
  endtask

  // Sends cipher_q, answers the start as the core would, checks exp_tx comes back.
  task automatic run_block(input logic [7:0] top, input int unsigned abort_at);
    logic [255:0] exp_a, res;
    int unsigned base, k;
    exp_a = '0;
    base  = start_cnt;
    foreach (cipher_q[i]) begin
      rx_q.push_back(cipher_q[i]);
      exp_a = {exp_a[247:0], cipher_q[i]};
    end
    res = 256'(top);
    foreach (exp_tx[i]) res = {res[247:0], exp_tx[i]};
    k = 0;
    while (start_cnt == base && k < 20000) begin tick(); k++; end
    chk("start_seen", 256'(start_cnt != base), 256'(1));
    chk("start_latency", 256'(start_ncyc), 256'(last_rx_ncyc + 1));
    chk("rsa_a", o_rsa_a, exp_a);
    chk("rsa_n_kept", o_rsa_n, exp_n);
    chk("rsa_d_kept", o_rsa_d, exp_d);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("calc_no_bus", 256'(avm_read | avm_write), 256'(0));
    end
    chk("start_once", 256'(start_cnt), 256'(base + 1));
    chk("rsa_a_stable", o_rsa_a, exp_a);
    i_rsa_finished = 1'b1;
    i_rsa_a_pow_d  = res;
    tick();
    i_rsa_finished = 1'b0;
    i_rsa_a_pow_d  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    if (abort_at != 0) begin
      k = 0;
      while (tx_q.size() < abort_at && k < 20000) begin tick(); k++; end
      chk("abort_reached", 256'(tx_q.size() >= abort_at), 256'(1));
    end else begin
      k = 0;
      while (tx_q.size() < 31 && k < 20000) begin tick(); k++; end
      repeat (20) tick();
      chk("tx_count", 256'(tx_q.size()), 256'(31));
      for (int i = 0; i < 31; i++) begin
        if (i < tx_q.size()) chk("tx_byte", 256'(tx_q[i]), 256'(exp_tx[i]));
      end
      tx_q.delete();
    end
  endtask

  task automatic random_block();
    cipher_q.delete();
    exp_tx.delete();
    for (int i = 0; i < 32; i++) cipher_q.push_back(8'($urandom));
    for (int i = 0; i < 31; i++) exp_tx.push_back(8'($urandom));
  endtask

  initial begin
    int unsigned k, sr;
    repeat (3) tick();
    chk_reset_outputs("reset");

    // Key load with slow slave: 3-cycle stalls and RX_OK held off for 5 polls per byte.
    i_rst = 1'b1;
    load_key(1'b1);
    k = 0;
    while (rx_q.size() > 0 && k < 20000) begin tick(); k++; end
    repeat (5) tick();
    chk("key_n", o_rsa_n, exp_n);
    chk("key_n_const", o_rsa_n, 256'h0102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f20);
    chk("key_d", o_rsa_d, {256{1'b1}});
    chk("no_start_yet", 256'(start_cnt), 256'(0));

    // A finished pulse while waiting for ciphertext must be ignored.
    i_rsa_finished = 1'b1;
    i_rsa_a_pow_d  = {8{32'hDEADBEEF}};
    tick();
    i_rsa_finished = 1'b0;
    repeat (40) tick();
    chk("spurious_no_tx", 256'(tx_q.size()), 256'(0));
    chk("spurious_no_start", 256'(start_cnt), 256'(0));

    cipher_q.delete();
    exp_tx.delete();
    for (int i = 0; i < 32; i++) cipher_q.push_back(8'hA5);
    for (int i = 1; i <= 31; i++) exp_tx.push_back(8'(i));
    run_block(8'h00, 0);

    fixed_stall = 1'b0;
    rx_hold = 1;
    random_block();
    run_block(8'($urandom), 0);
    random_block();
    run_block(8'($urandom), 0);

    // Reset while the 11th plaintext byte is in flight.
    random_block();
    run_block(8'($urandom), 10);
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    #1 chk_reset_outputs("mid_reset");
    tick();
    tick();
    rx_q.delete();
    tx_q.delete();
    i_rst = 1'b1;
    sr = status_reads;
    k = 0;
    while (status_reads == sr && k < 100) begin tick(); k++; end
    chk("repoll_after_reset", 256'(status_reads > sr), 256'(1));
    chk("key_cleared", o_rsa_n, 256'(0));
    load_key(1'b0);
    random_block();
    run_block(8'($urandom), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
